// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the access-size helper used by the fault check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_STORE,
        ST_RESP
    } lsu_state_t;

    // Bytes touched by an access; the low two funct3 bits encode the width.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between a memory word and the register file.
// The load path extracts and extends one lane; the store path merges new
// sub-word data into a word read back from memory.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed byte/halfword out of the memory word.
    always_comb begin
        byte_lane = word[{byte_off, 3'b000} +: 8];
        half_lane = byte_off[1] ? word[31:16] : word[15:0];
    end

    // Extend the selected lane to 32 bits according to the load type.
    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   load_data = {24'h0, byte_lane};
            F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
            F3_HU:   load_data = {16'h0, half_lane};
            default: load_data = word;
        endcase
    end

    // Overlay store data onto the addressed lane of the old word.
    always_comb begin
        // NOTE: every output of a combinational block gets a value before any
        // conditional overwrite; a path that leaves it unassigned infers a latch.
        merged_word = word;
        case (funct3[1:0])
            2'b00: merged_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (byte_off[1]) merged_word[31:16] = wdata[15:0];
                else             merged_word[15:0]  = wdata[15:0];
            end
            default: merged_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// CPU data-memory initiator. Takes one load/store at a time, drives a
// combinational-read / clocked-write word memory, and performs sub-word
// stores as read-modify-write. Illegal, misaligned and out-of-range
// requests answer with a fault and never strobe the memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

    lsu_state_t  state_q, state_d;

    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;     // store data, then merged word or load result
    logic        fault_q;

    logic        accept;
    logic        bad_funct3;
    logic        misaligned;
    logic        out_of_range;
    logic        fault;
    logic [2:0]  size;
    logic [32:0] end_addr;

    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign accept = req_valid && (state_q == ST_IDLE);

    // Classify the incoming request; the 33-bit end address keeps a request
    // near the top of the 32-bit space from wrapping back into range.
    always_comb begin
        size       = access_size(req_funct3);
        end_addr   = {1'b0, req_addr} + 33'(size);
        if (req_write)
            bad_funct3 = !(req_funct3 inside {F3_B, F3_H, F3_W});
        else
            bad_funct3 = req_funct3 inside {3'b011, 3'b110, 3'b111};
        misaligned   = ((size == 3'd2) && req_addr[0]) ||
                       ((size == 3'd4) && (req_addr[1:0] != 2'b00));
        out_of_range = end_addr > 33'(MEM_BYTES);
        fault        = bad_funct3 || misaligned || out_of_range;
    end

    lsu_lane_align u_lane_align (
        .funct3      (funct3_q),
        .byte_off    (addr_q[1:0]),
        .word        (mem_read_data),
        .wdata       (data_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (fault)                     state_d = ST_RESP;
                    else if (!req_write)           state_d = ST_LOAD;
                    else if (req_funct3 == F3_W)   state_d = ST_STORE;
                    else                           state_d = ST_RMW_RD;
                end
            end
            ST_LOAD:   state_d = ST_RESP;
            ST_RMW_RD: state_d = ST_STORE;
            ST_STORE:  state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request capture at acceptance and data updates in LOAD / RMW_RD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            data_q   <= 32'h0;
            fault_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        data_q   <= req_wdata;
                        fault_q  <= fault;
                    end
                end
                ST_LOAD:   data_q <= load_data;
                ST_RMW_RD: data_q <= merged_word;
                default:   ;
            endcase
        end
    end

    // Outputs decoded from state; address and data are zero without a strobe.
    always_comb begin
        req_ready      = (state_q == ST_IDLE);
        mem_read       = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
        mem_write      = (state_q == ST_STORE);
        mem_address    = 32'h0;
        mem_write_data = 32'h0;
        rsp_valid      = (state_q == ST_RESP);
        rsp_fault      = 1'b0;
        rsp_rdata      = 32'h0;
        if (mem_read || mem_write)
            mem_address = {addr_q[31:2], 2'b00};
        if (mem_write)
            mem_write_data = data_q;
        if (rsp_valid) begin
            rsp_fault = fault_q;
            if (!fault_q && !write_q)
                rsp_rdata = data_q;
        end
    end

endmodule
